// File: rtl/cfg_pkg.sv
// Shared types and constants for the per-tile configuration sequencer.
package cfg_pkg;

  localparam int TILE_ID_LSB = 0;
  localparam int TILE_ID_MSB = 15;
  localparam int REG_IDX_LSB = 16;
  localparam int REG_IDX_MSB = 31;

  localparam logic [15:0] BCAST_ID = 16'hFFFF;

  typedef struct packed {
    logic        last;
    logic [31:0] addr;
    logic [31:0] data;
  } cfg_word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_RUN
  } state_t;

endpackage

// File: rtl/cfg_fifo.sv
// Synchronous FIFO with extra-MSB pointers and registered full/empty flags.
module cfg_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 65
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign wr_nxt  = wr_ptr + (AW+1)'(do_push);
  assign rd_nxt  = rd_ptr + (AW+1)'(do_pop);

  // Flags are computed from next pointers so they are plain flops.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      empty  <= (wr_nxt == rd_nxt);
      full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/cfg_sequencer.sv
// Per-tile config sequencer: buffers, filters by tile ID, paces writes,
// and gates the tile into run mode after the final word.
module cfg_sequencer #(
  parameter int          DEPTH     = 8,
  parameter int          WRITE_GAP = 2,
  parameter logic [15:0] BCAST_ID  = 16'hFFFF
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [15:0] tile_id,
  input  logic        cfg_valid_in,
  output logic        cfg_ready_out,
  input  logic [31:0] cfg_addr_in,
  input  logic [31:0] cfg_data_in,
  input  logic        cfg_last_in,
  output logic [31:0] config_addr_out,
  output logic [31:0] config_data_out,
  output logic        config_we_out,
  output logic        tile_run_out,
  output logic        busy_out,
  output logic [15:0] words_written_out,
  output logic [15:0] words_skipped_out
);
  import cfg_pkg::*;

  localparam int GW = (WRITE_GAP > 1) ? $clog2(WRITE_GAP) : 1;

  cfg_word_t         wr_word, head;
  logic              full, empty, pop, hit, miss, last_q, gap_done, match;
  logic [GW-1:0]     gap_cnt;
  state_t            state, state_nxt;

  assign wr_word = '{last: cfg_last_in, addr: cfg_addr_in, data: cfg_data_in};

  cfg_fifo #(.DEPTH(DEPTH), .WIDTH($bits(cfg_word_t))) u_fifo (
    .clk_in (clk_in),
    .reset  (reset),
    .push   (cfg_valid_in),
    .wdata  (wr_word),
    .pop    (pop),
    .rdata  (head),
    .full   (full),
    .empty  (empty)
  );

  assign cfg_ready_out = !full;
  assign match    = (head.addr[TILE_ID_MSB:TILE_ID_LSB] == tile_id) ||
                    (head.addr[TILE_ID_MSB:TILE_ID_LSB] == BCAST_ID);
  assign gap_done = (gap_cnt == GW'(WRITE_GAP - 1));
  assign busy_out = !((state == S_IDLE) || (state == S_RUN)) || !empty;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    hit       = 1'b0;
    miss      = 1'b0;
    case (state)
      S_IDLE:  if (!empty) state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (empty) begin
          state_nxt = S_IDLE;
        end else begin
          pop  = 1'b1;
          hit  = match;
          miss = !match;
          if (WRITE_GAP > 0)  state_nxt = S_GAP;
          else if (head.last) state_nxt = S_RUN;
          else                state_nxt = S_ISSUE;
        end
      end
      S_GAP: begin
        if (gap_done) begin
          if (last_q)      state_nxt = S_RUN;
          else if (!empty) state_nxt = S_ISSUE;
          else             state_nxt = S_IDLE;
        end
      end
      S_RUN:   if (!empty) state_nxt = S_ISSUE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      gap_cnt           <= '0;
      last_q            <= 1'b0;
      config_addr_out   <= '0;
      config_data_out   <= '0;
      config_we_out     <= 1'b0;
      tile_run_out      <= 1'b0;
      words_written_out <= '0;
      words_skipped_out <= '0;
    end else begin
      state         <= state_nxt;
      config_we_out <= hit;
      // Run asserts one cycle into RUN and drops on the edge that leaves it.
      tile_run_out  <= (state == S_RUN) && empty;
      gap_cnt       <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
      if (pop) last_q <= head.last;
      if (hit) begin
        config_addr_out <= head.addr;
        config_data_out <= head.data;
        if (words_written_out != 16'hFFFF) words_written_out <= words_written_out + 16'd1;
      end
      if (miss && words_skipped_out != 16'hFFFF)
        words_skipped_out <= words_skipped_out + 16'd1;
    end
  end

endmodule
